gfx_fpint_sched: RTL

- Issue scheduler for the shared multi-lane FP/INT pipeline (`gfx_fpint`).
- Round-robin arbitrates among NREQ requesters (warp slots) and drives the unit's op, in_valid and abort.
- Tracks every in-flight op in a latency-matched shadow pipeline so each writeback carries requester ID and destination register.
- Enforces per-requester outstanding limits and writeback-buffer credits, because the unit has no backpressure.

---
 rtl/gfx_fpint_sched.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/gfx_fpint_sched.sv
// gfx_fpint_sched
// Issue scheduler for the shared multi-lane FP/INT pipeline (gfx_fpint).
// Arbitrates round-robin among NREQ warp-slot requesters, drives the unit's
// op/in_valid/abort, and tags every writeback with requester ID and
// destination using a latency-matched shadow pipeline. The unit has no
// backpressure, so issue is gated by per-requester outstanding limits and
// by writeback-buffer credits.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   req_valid/req_ready per-requester request / one-hot combinational grant
//   req_op, req_dst     per-requester packed op word and destination
//   kill                per-requester cancel (branch or flush)
//   fpint_in_valid/op   issue strobe and op to the unit
//   iss_id              requester of the current issue (regfile read select)
//   fpint_abort         kills the op issued the previous cycle
//   fpint_wb_valid      unit writeback valid, compared against the tracker
//   wb_valid/id/dst     tagged writeback
//   wb_credit_ret       consumer frees one writeback-buffer entry
//   busy                any op in flight
//   err_desync          sticky tracker/unit or credit mismatch
module gfx_fpint_sched #(
  parameter int NREQ    = 4,
  parameter int OP_W    = 32,
  parameter int DST_W   = 6,
  parameter int LAT     = 15,
  parameter int CREDITS = 4,
  parameter int MAX_OUT = 2,
  localparam int ID_W   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*OP_W-1:0]  req_op,
  input  logic [NREQ*DST_W-1:0] req_dst,
  input  logic [NREQ-1:0]       kill,
  output logic                  fpint_in_valid,
  output logic [OP_W-1:0]       fpint_op,
  output logic [ID_W-1:0]       iss_id,
  output logic                  fpint_abort,
  input  logic                  fpint_wb_valid,
  output logic                  wb_valid,
  output logic [ID_W-1:0]       wb_id,
  output logic [DST_W-1:0]      wb_dst,
  input  logic                  wb_credit_ret,
  output logic                  busy,
  output logic                  err_desync
);

  localparam int CR_W  = $clog2(CREDITS + 1);
  localparam int CNT_W = $clog2(MAX_OUT + 1);

  logic [CR_W-1:0]               credits;
  logic [CNT_W-1:0]              out_cnt [NREQ];
  logic [ID_W-1:0]               ptr;
  logic [ID_W-1:0]               win_id;
  logic [NREQ-1:0]               eligible;
  logic [NREQ-1:0]               grant;
  logic                          hs;
  logic                          abort_nxt;
  logic                          ret_ok;
  logic [DST_W-1:0]              iss_dst;
  logic [LAT-1:0]                trk_v;
  logic [LAT-1:0][ID_W-1:0]      trk_id;
  logic [LAT-1:0][DST_W-1:0]     trk_dst;

  // Per-requester eligibility and outstanding counters. A requester whose
  // op is issued, written back and aborted in the same cycle nets correctly
  // because all three terms are summed into one update.
  for (genvar g = 0; g < NREQ; g++) begin : g_req
    logic inc, dec_wb, dec_ab;

    assign eligible[g] = req_valid[g] & ~kill[g] &
                         (out_cnt[g] < CNT_W'(MAX_OUT)) & (credits != '0);
    assign inc    = hs & (win_id == ID_W'(g));
    assign dec_wb = wb_valid & (wb_id == ID_W'(g));
    assign dec_ab = fpint_abort & (trk_id[0] == ID_W'(g));

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) out_cnt[g] <= '0;
      else        out_cnt[g] <= out_cnt[g] + CNT_W'(inc) - CNT_W'(dec_wb) - CNT_W'(dec_ab);
    end
  end

  // Round-robin arbiter: the first eligible index after the pointer wins.
  always_comb begin
    logic             found;
    logic [ID_W-1:0]  idx;
    grant  = '0;
    win_id = '0;
    found  = 1'b0;
    idx    = '0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = ID_W'((int'(ptr) + k) % NREQ);
      if (!found && eligible[idx]) begin
        found       = 1'b1;
        grant[idx]  = 1'b1;
        win_id      = idx;
      end
    end
  end

  assign req_ready = grant;
  assign hs        = |grant;

  // An issued op is aborted when its requester is killed while the op is on
  // the unit's input. A credit return with a full buffer is a consumer bug.
  assign abort_nxt = fpint_in_valid & kill[iss_id];
  assign ret_ok    = wb_credit_ret & (credits != CR_W'(CREDITS));

  // Arbiter pointer moves to the winner only on an actual handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  ptr <= ID_W'(NREQ - 1);
    else if (hs) ptr <= win_id;
  end

  // Issue register stage: what the unit sees one cycle after the grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fpint_in_valid <= 1'b0;
      fpint_op       <= '0;
      iss_id         <= '0;
      iss_dst        <= '0;
      fpint_abort    <= 1'b0;
    end else begin
      fpint_in_valid <= hs;
      fpint_abort    <= abort_nxt;
      if (hs) begin
        fpint_op <= req_op[int'(win_id)*OP_W +: OP_W];
        iss_id   <= win_id;
        iss_dst  <= req_dst[int'(win_id)*DST_W +: DST_W];
      end
    end
  end

  // Shadow pipeline. Stage 0 is written as the op leaves the issue stage and
  // the last stage lines up with the unit's writeback. An aborted op enters
  // stage 0 already invalid, so by the time fpint_abort is visible the entry
  // is dead; its ID stays in stage 0 for the outstanding-counter decrement.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      trk_v   <= '0;
      trk_id  <= '0;
      trk_dst <= '0;
    end else begin
      trk_v   <= {trk_v[LAT-2:0], fpint_in_valid & ~abort_nxt};
      trk_id  <= {trk_id[LAT-2:0], iss_id};
      trk_dst <= {trk_dst[LAT-2:0], iss_dst};
    end
  end

  assign wb_valid = trk_v[LAT-1];
  assign wb_id    = trk_id[LAT-1];
  assign wb_dst   = trk_dst[LAT-1];

  // Credit counter: issue consumes, consumer return and abort give back.
  // Eligibility only sees the registered value, so a return helps next cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) credits <= CR_W'(CREDITS);
    else        credits <= credits - CR_W'(hs) + CR_W'(ret_ok) + CR_W'(fpint_abort);
  end

  // Sticky error: unit writeback disagrees with the tracker, or the consumer
  // returned a credit it never held.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_desync <= 1'b0;
    else if ((fpint_wb_valid != wb_valid) || (wb_credit_ret && !ret_ok))
      err_desync <= 1'b1;
  end

  assign busy = (|trk_v) | fpint_in_valid | fpint_abort;

endmodule
